// File: rtl/word_to_bytes.sv
// word_to_bytes: serializes 32-bit words into 4 bytes with valid/ready handshakes on both sides.
module word_to_bytes #(
  parameter bit SWAP = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic        in_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_data,
  output logic        out_last,
  output logic        busy
);
  typedef enum logic {IDLE, SEND} state_t;
  state_t state, state_n;
  logic [1:0] idx, idx_n, sel;
  logic [31:0] held, held_n;
  logic held_last, held_last_n;
  logic accept, xfer;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      idx <= 2'd0;
      held <= 32'h0;
      held_last <= 1'b0;
    end else begin
      state <= state_n;
      idx <= idx_n;
      held <= held_n;
      held_last <= held_last_n;
    end
  end
  // A new word may land on the same edge the fourth byte leaves, so back-to-back words have no bubble.
  always_comb begin
    busy = state == SEND;
    out_valid = busy;
    in_ready = !busy || (idx == 2'd3 && out_ready);
    sel = SWAP ? idx : ~idx;
    out_data = busy ? held[{sel, 3'b000} +: 8] : 8'h00;
    out_last = busy && idx == 2'd3 && held_last;
    accept = in_valid && in_ready;
    xfer = out_valid && out_ready;
    state_n = state;
    idx_n = idx;
    held_n = held;
    held_last_n = held_last;
    if (accept) begin
      state_n = SEND;
      idx_n = 2'd0;
      held_n = in_data;
      held_last_n = in_last;
    end else if (xfer) begin
      state_n = idx == 2'd3 ? IDLE : SEND;
      idx_n = idx + 2'd1;
    end
  end
endmodule

// File: doc/word_to_bytes.md
WORD_TO_BYTES -- requirements
Module: word_to_bytes

Interface
REQ-001 The block SHALL have parameter SWAP, default 0: 0 = emit bytes MSB-first (bits 31:24 first); 1 = emit LSB-first (bits 7:0 first), the byte-swapped order.
REQ-002 The block SHALL have one clock and an asynchronous, active-high reset: clk (input, 1) is the sole clock and rst (input, 1) is the asynchronous active-high reset.
REQ-003 in_valid  input  1  upstream word valid.
REQ-004 in_ready  output  1  block can accept a word this cycle.
REQ-005 in_data  input  32  word to serialize.
REQ-006 in_last  input  1  word ends a packet.
REQ-007 out_valid  output  1  out_data holds a valid byte.
REQ-008 out_ready  input  1  downstream accepts a byte this cycle.
REQ-009 out_data  output  8  current byte.
REQ-010 out_last  output  1  final byte of a word marked in_last.
REQ-011 busy  output  1  word held, not fully emitted.

Function
REQ-012 A word SHALL be accepted on a rising clk edge where in_valid && in_ready; an out byte SHALL transfer on a rising edge where out_valid && out_ready.
REQ-013 The block SHALL use two states, IDLE (no word held) and SEND (word held), plus a 2-bit byte index idx and a 32-bit holding register with a 1-bit last flag.
REQ-014 IDLE: in_ready=1, out_valid=0; on accept, capture in_data/in_last, set idx=0, go SEND.
REQ-015 SEND: out_valid=1; out_data = byte selected by idx (SWAP=0: idx 0..3 -> bits 31:24, 23:16, 15:8, 7:0; SWAP=1: idx 0..3 -> bits 7:0, 15:8, 23:16, 31:24).
REQ-016 SEND: on byte transfer with idx<3, idx SHALL increment by 1; holding register unchanged.
REQ-017 SEND: in_ready SHALL equal (idx==3 && out_ready), giving zero-bubble back-to-back words.
REQ-018 SEND, idx==3, byte transfers, and a word is accepted the same edge: capture new word, idx=0, stay SEND.
REQ-019 SEND, idx==3, byte transfers, and no word is accepted: go IDLE, idx=0.
REQ-020 out_last SHALL be 1 only in SEND with idx==3 and the held last flag set.
REQ-021 out_data, out_last and in_ready SHALL be stable while out_valid && !out_ready (stall); in_data is not sampled outside an accept edge.
REQ-022 busy SHALL equal (state==SEND).
REQ-023 Exactly 4 byte transfers SHALL occur per accepted word; the index SHALL never wrap past 3 without leaving the word.
REQ-024 Latency: first byte valid the cycle after the accept edge; a word with out_ready held at 1 drains in 4 cycles.

Reset
REQ-025 rst SHALL asynchronously force state=IDLE, idx=0, holding register=0, last flag=0, regardless of clk.
REQ-026 During and immediately after reset: out_valid=0, out_last=0, out_data=8'h00, busy=0, in_ready=1.
REQ-027 Reset mid-word SHALL discard remaining bytes; the first accept after deassertion starts a fresh word at idx=0.

Verification
REQ-028 SWAP=0, word 32'hdeadbeef, in_last=1, out_ready=1 -> bytes de, ad, be, ef on 4 consecutive cycles, out_last only with ef, then IDLE.
REQ-029 SWAP=1, word 32'hfeedface, in_last=0 -> bytes ce, fa, ed, fe, out_last never asserted.
REQ-030 SWAP=0, words 32'h01020304 then 32'h05060708 offered back-to-back, out_ready=1 -> 8 contiguous bytes 01..08, no bubble, in_ready high only on the edges completing byte 04 and 08.
REQ-031 SWAP=0, 32'hdeadbeef, out_ready low for 3 cycles at idx=1 -> out_data held at ad, idx frozen, then be, ef resume; total 4 transfers.
REQ-032 rst pulsed asynchronously (between clk edges) after byte ad -> out_valid drops immediately; next word 32'h11223344 emits 11, 22, 33, 44.
REQ-033 in_valid asserted while busy with idx<3 -> no accept, in_ready=0, held word unchanged.
